cache_mem_arbiter: RTL and testbench

//  Sits between the CPU core's cache refill/write-back ports and the external memory controller.

---
 rtl/cache_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - serialises I-cache/D-cache refills and D-cache write-backs onto one memory channel
module cache_mem_arbiter #(
    parameter int RD_BEATS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         icr_start_rq,
    input  logic [31:0]  ic_rin_addr,
    output logic [127:0] ic_rdat_m_data,
    output logic [15:0]  ic_rdat_m_mask,
    output logic         ic_rdat_m_valid,
    output logic         ic_finish_mrd,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    output logic         rqfull_1,
    output logic [127:0] rdat_m_data,
    output logic         rdat_m_valid,
    output logic         finish_mrd,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         dcw_finish_wresp,
    output logic         mem_req,
    output logic         mem_we,
    output logic [27:0]  mem_addr,
    output logic [15:0]  mem_wmask,
    output logic [127:0] mem_wdata,
    input  logic         mem_ack,
    input  logic         mem_rvalid,
    input  logic [127:0] mem_rdata,
    input  logic         mem_wresp,
    output logic         arb_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, WAIT_WR} state_t;
    typedef enum logic [1:0] {G_IC, G_DR, G_DW} grant_t;

    state_t       state, state_nx;
    grant_t       gnt, gnt_nx;
    logic         ic_occ, dr_occ, dw_occ;
    logic [27:0]  ic_addr_q, dr_addr_q, dw_addr_q;
    logic [15:0]  dw_mask_q;
    logic [127:0] dw_data_q;
    logic [3:0]   beat_cnt;
    logic         ic_acc, dr_acc, dw_acc;
    logic         beat, last_beat, wr_done, any_pend, issue;
    logic [27:0]  sel_addr;
    logic         unused_addr_lsbs;

    assign ic_acc    = icr_start_rq & ~ic_occ;
    assign dr_acc    = dcr_start_rq & ~dr_occ;
    assign dw_acc    = dcw_start_rq & ~dw_occ;
    assign beat      = (state == WAIT_RD) & mem_rvalid;
    assign last_beat = beat & (beat_cnt == 4'(RD_BEATS - 1));
    assign wr_done   = (state == WAIT_WR) & mem_wresp;
    assign any_pend  = ic_occ | dr_occ | dw_occ | icr_start_rq | dcr_start_rq | dcw_start_rq;
    assign issue     = (state == IDLE) & any_pend;
    assign rqfull_1  = dr_occ;
    assign unused_addr_lsbs = ^{ic_rin_addr[3:0], dcr_rin_addr[3:0], dcw_in_addr[3:0]};

    // A start pulse arriving while IDLE is granted directly from the inputs, so mem_req
    // rises one cycle after the pulse. Later assignments win: DC-wr > DC-rd > IC-rd.
    always_comb begin
        gnt_nx   = G_IC;
        sel_addr = ic_occ ? ic_addr_q : ic_rin_addr[31:4];
        if (dr_occ || dcr_start_rq) begin
            gnt_nx   = G_DR;
            sel_addr = dr_occ ? dr_addr_q : dcr_rin_addr[31:4];
        end
        if (dw_occ || dcw_start_rq) begin
            gnt_nx   = G_DW;
            sel_addr = dw_occ ? dw_addr_q : dcw_in_addr[31:4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_pend) state_nx = REQ;
            REQ:     if (mem_ack) state_nx = mem_we ? WAIT_WR : WAIT_RD;
            WAIT_RD: if (last_beat) state_nx = IDLE;
            WAIT_WR: if (mem_wresp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ);
    end

    // Slot occupancy: set on an accepted start, cleared together with the finish pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ic_occ    <= 1'b0;
            dr_occ    <= 1'b0;
            dw_occ    <= 1'b0;
            ic_addr_q <= '0;
            dr_addr_q <= '0;
            dw_addr_q <= '0;
            dw_mask_q <= '0;
            dw_data_q <= '0;
            arb_err   <= 1'b0;
        end else begin
            if (ic_acc) begin
                ic_occ    <= 1'b1;
                ic_addr_q <= ic_rin_addr[31:4];
            end else if (last_beat && gnt == G_IC) begin
                ic_occ <= 1'b0;
            end
            if (dr_acc) begin
                dr_occ    <= 1'b1;
                dr_addr_q <= dcr_rin_addr[31:4];
            end else if (last_beat && gnt == G_DR) begin
                dr_occ <= 1'b0;
            end
            if (dw_acc) begin
                dw_occ    <= 1'b1;
                dw_addr_q <= dcw_in_addr[31:4];
                dw_mask_q <= dcw_in_mask;
                dw_data_q <= dcw_in_data;
            end else if (wr_done) begin
                dw_occ <= 1'b0;
            end
            if ((icr_start_rq && ic_occ) || (dcr_start_rq && dr_occ) || (dcw_start_rq && dw_occ)) begin
                arb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt              <= G_IC;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wmask        <= '0;
            mem_wdata        <= '0;
            beat_cnt         <= '0;
            ic_rdat_m_data   <= '0;
            ic_rdat_m_mask   <= '0;
            ic_rdat_m_valid  <= 1'b0;
            ic_finish_mrd    <= 1'b0;
            rdat_m_data      <= '0;
            rdat_m_valid     <= 1'b0;
            finish_mrd       <= 1'b0;
            dcw_finish_wresp <= 1'b0;
        end else begin
            if (issue) begin
                gnt       <= gnt_nx;
                mem_we    <= (gnt_nx == G_DW);
                mem_addr  <= sel_addr;
                mem_wmask <= (gnt_nx == G_DW) ? (dw_occ ? dw_mask_q : dcw_in_mask) : 16'h0;
                mem_wdata <= (gnt_nx == G_DW) ? (dw_occ ? dw_data_q : dcw_in_data) : 128'h0;
            end
            if (state == REQ) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
            end
            ic_rdat_m_valid  <= beat && gnt == G_IC;
            ic_rdat_m_mask   <= (beat && gnt == G_IC) ? 16'hffff : 16'h0;
            ic_finish_mrd    <= last_beat && gnt == G_IC;
            rdat_m_valid     <= beat && gnt == G_DR;
            finish_mrd       <= last_beat && gnt == G_DR;
            dcw_finish_wresp <= wr_done;
            if (beat && gnt == G_IC) ic_rdat_m_data <= mem_rdata;
            if (beat && gnt == G_DR) rdat_m_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter (RD_BEATS=4 main, RD_BEATS=1 side instance)
module tb_cache_mem_arbiter;

    localparam int RDB = 4;

    typedef struct packed {
        logic         we;
        logic [27:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
    } mreq_t;

    typedef struct packed {
        logic [127:0] data;
        logic         fin;
    } beat_t;

    logic clk;
    logic rst_n;

    logic         icr_start_rq, dcr_start_rq, dcw_start_rq;
    logic [31:0]  ic_rin_addr, dcr_rin_addr, dcw_in_addr;
    logic [15:0]  dcw_in_mask;
    logic [127:0] dcw_in_data;
    logic [127:0] ic_rdat_m_data, rdat_m_data, mem_wdata, mem_rdata;
    logic [15:0]  ic_rdat_m_mask, mem_wmask;
    logic         ic_rdat_m_valid, ic_finish_mrd, rqfull_1, rdat_m_valid, finish_mrd;
    logic         dcw_finish_wresp, mem_req, mem_we, mem_ack, mem_rvalid, mem_wresp, arb_err;
    logic [27:0]  mem_addr;

    logic         b_icr, b_ack, b_rvalid;
    logic [31:0]  b_ic_addr;
    logic [127:0] b_rdata, b_ic_data;
    logic [15:0]  b_ic_mask;
    logic         b_ic_valid, b_ic_fin, b_mem_req, b_mem_we;
    logic [27:0]  b_mem_addr;
    logic         b_unused_rqfull, b_unused_rvalid, b_unused_fin, b_unused_wfin, b_unused_err;
    logic [127:0] b_unused_rdata, b_unused_wdata;
    logic [15:0]  b_unused_wmask;

    mreq_t exp_mem[$];
    beat_t exp_ic[$];
    beat_t exp_dc[$];
    beat_t exp_ic1[$];
    logic  exp_wr[$];

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.RD_BEATS(RDB)) dut (
        .clk(clk), .rst_n(rst_n),
        .icr_start_rq(icr_start_rq), .ic_rin_addr(ic_rin_addr),
        .ic_rdat_m_data(ic_rdat_m_data), .ic_rdat_m_mask(ic_rdat_m_mask),
        .ic_rdat_m_valid(ic_rdat_m_valid), .ic_finish_mrd(ic_finish_mrd),
        .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr), .rqfull_1(rqfull_1),
        .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
        .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_mask(dcw_in_mask),
        .dcw_in_data(dcw_in_data), .dcw_finish_wresp(dcw_finish_wresp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_wresp(mem_wresp), .arb_err(arb_err)
    );

    cache_mem_arbiter #(.RD_BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .icr_start_rq(b_icr), .ic_rin_addr(b_ic_addr),
        .ic_rdat_m_data(b_ic_data), .ic_rdat_m_mask(b_ic_mask),
        .ic_rdat_m_valid(b_ic_valid), .ic_finish_mrd(b_ic_fin),
        .dcr_start_rq(1'b0), .dcr_rin_addr(32'h0), .rqfull_1(b_unused_rqfull),
        .rdat_m_data(b_unused_rdata), .rdat_m_valid(b_unused_rvalid), .finish_mrd(b_unused_fin),
        .dcw_start_rq(1'b0), .dcw_in_addr(32'h0), .dcw_in_mask(16'h0),
        .dcw_in_data(128'h0), .dcw_finish_wresp(b_unused_wfin),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wmask(b_unused_wmask),
        .mem_wdata(b_unused_wdata), .mem_ack(b_ack), .mem_rvalid(b_rvalid),
        .mem_rdata(b_rdata), .mem_wresp(1'b0), .arb_err(b_unused_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory model read data: line address and beat index folded into a fixed pattern.
    function automatic logic [127:0] rd_data(input logic [27:0] a, input int b);
        return {a, 4'(b), 96'h0123_4567_89ab_cdef_5a5a_c3c3};
    endfunction

    function automatic mreq_t mk_req(input logic we, input logic [27:0] a,
                                     input logic [15:0] m, input logic [127:0] d);
        mreq_t r;
        r.we = we; r.addr = a; r.mask = m; r.data = d;
        return r;
    endfunction

    function automatic beat_t mk_beat(input logic [127:0] d, input logic fin);
        beat_t r;
        r.data = d; r.fin = fin;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responds to one main-DUT request: optional ack hold-off, then beats (with gaps) or a write response.
    task automatic serve(input int ack_dly, input int gap);
        int n;
        logic we;
        logic [27:0] a;
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("mem_req_wait", 192'(mem_req), 192'(1'b1));
        if (mem_req !== 1'b1) return;
        repeat (ack_dly) tick();
        we = mem_we;
        a  = mem_addr;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        if (we) begin
            repeat (2) tick();
            mem_wresp = 1'b1;
            tick();
            mem_wresp = 1'b0;
        end else begin
            for (int b = 0; b < RDB; b++) begin
                repeat (gap) tick();
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data(a, b);
                tick();
                mem_rvalid = 1'b0;
            end
        end
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUTs present an output event.
    initial begin
        mreq_t m, mc, prev, e;
        beat_t eb;
        logic prev_pend, prev_ack;
        prev_pend = 1'b0;
        prev_ack  = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_pend = 1'b0;
                prev_ack  = 1'b0;
            end else begin
                m = mk_req(mem_we, mem_addr, mem_wmask, mem_wdata);
                if (prev_ack) chk("mem_req_drop", 192'(mem_req), 192'(1'b0));
                if (prev_pend && mem_req) chk("req_fields_stable", 192'(m), 192'(prev));
                if (mem_req && mem_ack) begin
                    chk("mem_unexpected", 192'(exp_mem.size() != 0), 192'(1'b1));
                    if (exp_mem.size() != 0) begin
                        e  = exp_mem.pop_front();
                        mc = m;
                        if (!e.we) begin
                            mc.mask = '0; mc.data = '0; e.mask = '0; e.data = '0;
                        end
                        chk("mem_request", 192'(mc), 192'(e));
                    end
                end
                prev_pend = mem_req && !mem_ack;
                prev_ack  = mem_req && mem_ack;
                prev      = m;
                if (ic_rdat_m_valid || ic_finish_mrd) begin
                    chk("ic_unexpected", 192'(exp_ic.size() != 0), 192'(1'b1));
                    if (exp_ic.size() != 0) begin
                        eb = exp_ic.pop_front();
                        chk("ic_beat", 192'({ic_rdat_m_valid, ic_rdat_m_mask, ic_finish_mrd, ic_rdat_m_data}),
                            192'({1'b1, 16'hffff, eb.fin, eb.data}));
                    end
                end
                if (rdat_m_valid || finish_mrd) begin
                    chk("dc_unexpected", 192'(exp_dc.size() != 0), 192'(1'b1));
                    if (exp_dc.size() != 0) begin
                        eb = exp_dc.pop_front();
                        chk("dc_beat", 192'({rdat_m_valid, finish_mrd, rqfull_1, rdat_m_data}),
                            192'({1'b1, eb.fin, ~eb.fin, eb.data}));
                    end
                end
                if (dcw_finish_wresp) begin
                    chk("wr_unexpected", 192'(exp_wr.size() != 0), 192'(1'b1));
                    if (exp_wr.size() != 0) void'(exp_wr.pop_front());
                end
                if (b_ic_valid || b_ic_fin) begin
                    chk("ic1_unexpected", 192'(exp_ic1.size() != 0), 192'(1'b1));
                    if (exp_ic1.size() != 0) begin
                        eb = exp_ic1.pop_front();
                        chk("ic1_beat", 192'({b_ic_valid, b_ic_mask, b_ic_fin, b_ic_data}),
                            192'({1'b1, 16'hffff, eb.fin, eb.data}));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        icr_start_rq = 1'b0; dcr_start_rq = 1'b0; dcw_start_rq = 1'b0;
        ic_rin_addr = '0; dcr_rin_addr = '0; dcw_in_addr = '0; dcw_in_mask = '0; dcw_in_data = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_wresp = 1'b0;
        b_icr = 1'b0; b_ic_addr = '0; b_ack = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", 192'({mem_req, mem_we, mem_addr, mem_wmask, rqfull_1, arb_err, rdat_m_valid,
                                finish_mrd, ic_rdat_m_valid, ic_finish_mrd, ic_rdat_m_mask, dcw_finish_wresp}), 192'(0));
        chk("reset_data", 192'(rdat_m_data | ic_rdat_m_data | mem_wdata), 192'(0));
        chk("reset_side", 192'({b_mem_req, b_mem_addr, b_ic_valid, b_ic_fin, b_ic_mask}), 192'(0));
        tick();

        // Single I-cache read on the RD_BEATS=1 instance
        b_icr = 1'b1;
        b_ic_addr = 32'h0000_1230;
        exp_ic1.push_back(mk_beat(rd_data(28'h000_0123, 0), 1'b1));
        tick();
        b_icr = 1'b0;
        chk("ic1_mem_req", 192'({b_mem_req, b_mem_we, b_mem_addr}), 192'({1'b1, 1'b0, 28'h000_0123}));
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        b_rvalid = 1'b1;
        b_rdata = rd_data(28'h000_0123, 0);
        tick();
        b_rvalid = 1'b0;
        repeat (2) tick();

        // D-cache read, 4 beats with gaps; low address bits ignored
        dcr_start_rq = 1'b1;
        dcr_rin_addr = 32'h0000_abc4;
        exp_mem.push_back(mk_req(1'b0, 28'h000_0abc, 16'h0, 128'h0));
        for (int b = 0; b < RDB; b++) exp_dc.push_back(mk_beat(rd_data(28'h000_0abc, b), (b == RDB - 1)));
        tick();
        dcr_start_rq = 1'b0;
        chk("rqfull_rise", 192'(rqfull_1), 192'(1'b1));
        chk("req_latency", 192'(mem_req), 192'(1'b1));
        serve(0, 2);
        chk("rqfull_fall", 192'(rqfull_1), 192'(1'b0));

        // Second start into an occupied DC-rd slot is dropped
        dcr_start_rq = 1'b1;
        dcr_rin_addr = 32'h0000_1110;
        exp_mem.push_back(mk_req(1'b0, 28'h000_0111, 16'h0, 128'h0));
        for (int b = 0; b < RDB; b++) exp_dc.push_back(mk_beat(rd_data(28'h000_0111, b), (b == RDB - 1)));
        tick();
        dcr_rin_addr = 32'h0000_2220;
        tick();
        dcr_start_rq = 1'b0;
        chk("arb_err_set", 192'(arb_err), 192'(1'b1));
        serve(0, 0);
        repeat (5) tick();
        chk("no_second_read", 192'(mem_req), 192'(1'b0));

        // All three at once: write, then D-read, then I-read; ack held off 10 cycles on the write
        dcw_start_rq = 1'b1; dcr_start_rq = 1'b1; icr_start_rq = 1'b1;
        dcw_in_addr = 32'h0000_2008; dcw_in_mask = 16'h0ff0;
        dcw_in_data = 128'hfeed_beef_0000_1111_2222_3333_4444_5555;
        dcr_rin_addr = 32'h0000_2000; ic_rin_addr = 32'h0000_3010;
        exp_mem.push_back(mk_req(1'b1, 28'h000_0200, 16'h0ff0, 128'hfeed_beef_0000_1111_2222_3333_4444_5555));
        exp_mem.push_back(mk_req(1'b0, 28'h000_0200, 16'h0, 128'h0));
        exp_mem.push_back(mk_req(1'b0, 28'h000_0301, 16'h0, 128'h0));
        exp_wr.push_back(1'b1);
        for (int b = 0; b < RDB; b++) begin
            exp_dc.push_back(mk_beat(rd_data(28'h000_0200, b), (b == RDB - 1)));
            exp_ic.push_back(mk_beat(rd_data(28'h000_0301, b), (b == RDB - 1)));
        end
        tick();
        dcw_start_rq = 1'b0; dcr_start_rq = 1'b0; icr_start_rq = 1'b0;
        dcw_in_data = '0; dcw_in_mask = '0;
        serve(10, 0);
        serve(0, 1);
        serve(0, 0);

        // Reset in WAIT_RD, then a stray beat
        dcr_start_rq = 1'b1;
        dcr_rin_addr = 32'h0000_5550;
        exp_mem.push_back(mk_req(1'b0, 28'h000_0555, 16'h0, 128'h0));
        tick();
        dcr_start_rq = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 128'hbad0_bad0;
        tick();
        mem_rvalid = 1'b0;
        repeat (2) tick();
        chk("abort_ctrl", 192'({mem_req, rqfull_1, arb_err, rdat_m_valid, finish_mrd,
                                ic_rdat_m_valid, ic_finish_mrd, dcw_finish_wresp}), 192'(0));
        chk("abort_data", 192'(rdat_m_data | ic_rdat_m_data), 192'(0));

        repeat (3) tick();
        chk("exp_mem_left", 192'(exp_mem.size()), 192'(0));
        chk("exp_ic_left", 192'(exp_ic.size()), 192'(0));
        chk("exp_dc_left", 192'(exp_dc.size()), 192'(0));
        chk("exp_wr_left", 192'(exp_wr.size()), 192'(0));
        chk("exp_ic1_left", 192'(exp_ic1.size()), 192'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
